// File: rtl/parity_mem_path.sv
// parity_mem_path: byte datapath with odd-parity protection.
// Write data gets an odd-parity bit. Data and parity are stored together in a
// small register file. The parity of the read-back word is checked on every read.
// Optional feature: define PARITY_INJECT_EN to add an 'inj' input. A write with
// inj=1 stores the inverted parity bit, which gives a deliberate parity error.
module parity_mem_path #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
`ifdef PARITY_INJECT_EN
  input  logic              inj,
`endif
  output logic              pgen,
  output logic [7:0]        dout,
  output logic              pout,
  output logic              dout_vld,
  output logic              pe,
  output logic              err
);

  // Each stored word is {data, parity}. Reset fills every word with {0x00, 1},
  // which is a valid odd-parity word.
  logic [8:0] mem [DEPTH];
  logic       armed;
  logic       pgen_w;

  assign pgen = ~^din;

`ifdef PARITY_INJECT_EN
  assign pgen_w = pgen ^ inj;
`else
  assign pgen_w = pgen;
`endif

  assign pe  = ~^{dout, pout};
  assign err = dout_vld & pe;

  // Blocks any access on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Register-file write port. A simultaneous read does not block the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 9'h001;
    end else if (armed && wr) begin
      mem[addr] <= {din, pgen_w};
    end
  end

  // Registered read port. A read only happens when no write is in the same cycle.
  // Otherwise the data holds and the valid pulse drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= 8'h00;
      pout     <= 1'b1;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (armed && rd && !wr) begin
        {dout, pout} <= mem[addr];
        dout_vld     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_mem_path.sv
// Testbench for parity_mem_path. It runs directed scenarios and then random
// traffic. All results are compared against a behavioural memory model.
module tb_parity_mem_path;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [3:0] addr;
  logic [7:0] din;
  logic       inj;
  logic       pgen;
  logic [7:0] dout;
  logic       pout;
  logic       dout_vld;
  logic       pe;
  logic       err;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0] model_data [16];
  logic       model_par  [16];
  logic [7:0] exp_dout;
  logic       exp_pout;
  logic       exp_vld;

  parity_mem_path #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .din      (din),
`ifdef PARITY_INJECT_EN
    .inj      (inj),
`endif
    .pgen     (pgen),
    .dout     (dout),
    .pout     (pout),
    .dout_vld (dout_vld),
    .pe       (pe),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Odd parity bit: 1 when the byte holds an even number of ones
  function automatic logic odd_bit(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      model_data[i] = 8'h00;
      model_par[i]  = 1'b1;
    end
    exp_dout = 8'h00;
    exp_pout = 1'b1;
    exp_vld  = 1'b0;
  endtask

  task automatic check_read_side(input string tag);
    logic exp_pe;
    exp_pe = ($countones({exp_dout, exp_pout}) % 2 == 0);
    checkOutput({tag, ".dout"}, dout, exp_dout);
    checkOutput({tag, ".pout"}, pout, exp_pout);
    checkOutput({tag, ".vld"},  dout_vld, exp_vld);
    checkOutput({tag, ".pe"},   pe, exp_pe);
    checkOutput({tag, ".err"},  err, exp_vld & exp_pe);
  endtask

  // One clocked access. Inputs are driven mid-cycle, and pgen is checked
  // before the edge. Model results are checked just after the edge.
  task automatic applyStimulus(input string tag, input logic w, input logic r,
                               input logic [3:0] a, input logic [7:0] d, input logic i);
    logic stored_par;
    wr = w; rd = r; addr = a; din = d; inj = i;
    #1;
    checkOutput({tag, ".pgen"}, pgen, odd_bit(d));
    @(posedge clk);
`ifdef PARITY_INJECT_EN
    stored_par = odd_bit(d) ^ i;
`else
    stored_par = odd_bit(d);
`endif
    if (w) begin
      model_data[a] = d;
      model_par[a]  = stored_par;
      exp_vld = 1'b0;
    end else if (r) begin
      exp_dout = model_data[a];
      exp_pout = model_par[a];
      exp_vld  = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    #1;
    check_read_side(tag);
  endtask

  // Releases reset mid-cycle. A write is attempted on the first edge after
  // release, and the model expects it to be ignored.
  task automatic release_reset();
    rst_n = 1'b1;
    wr = 1'b1; rd = 1'b0; addr = 4'd3; din = 8'h5A; inj = 1'b0;
    @(posedge clk);
    #1;
    check_read_side("rel");
  endtask

  initial begin
    rst_n = 1'b0;
    wr = 1'b0; rd = 1'b0; addr = '0; din = '0; inj = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_read_side("reset");
    release_reset();

    // Scenario 1: read of a location never written
    applyStimulus("t1.rd0", 1'b0, 1'b1, 4'd0, 8'h00, 1'b0);
    applyStimulus("t1.idle", 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    applyStimulus("t1.rd3", 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    // Scenario 2: write 0x24 (pgen=1)
    applyStimulus("t2.wr", 1'b1, 1'b0, 4'd3, 8'h24, 1'b0);
    applyStimulus("t2.rd", 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    // Scenario 3: write 0x07 (pgen=0)
    applyStimulus("t3.wr", 1'b1, 1'b0, 4'd5, 8'h07, 1'b0);
    applyStimulus("t3.rd5", 1'b0, 1'b1, 4'd5, 8'h00, 1'b0);
    applyStimulus("t3.rd3", 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
    // Scenario 4: read and write together, so the write wins
    applyStimulus("t4.rw", 1'b1, 1'b1, 4'd2, 8'hFF, 1'b0);
    applyStimulus("t4.rd", 1'b0, 1'b1, 4'd2, 8'h00, 1'b0);
    applyStimulus("t4.hold", 1'b0, 1'b0, 4'd2, 8'h81, 1'b0);
    // Scenario 5: reset asserted mid-read
    wr = 1'b0; rd = 1'b1; addr = 4'd3;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_read_side("t5.rst");
    @(posedge clk);
    #2;
    release_reset();
    applyStimulus("t5.rd3", 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
`ifdef PARITY_INJECT_EN
    // Scenario 6: deliberately inject a bad parity bit
    applyStimulus("t6.wr", 1'b1, 1'b0, 4'd1, 8'h24, 1'b1);
    applyStimulus("t6.rd", 1'b0, 1'b1, 4'd1, 8'h00, 1'b0);
    applyStimulus("t6.hold", 1'b0, 1'b0, 4'd1, 8'h00, 1'b0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rnd",
                    ($urandom % 3) == 0,
                    ($urandom % 2) == 1,
                    4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)),
                    ($urandom % 8) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
